// File: rtl/prm_xyz_sweep_if.sv
// Checker-side bus of the XYZ sweep engine.
//   sel1, sel2  : selectors latched at sweep start, driven to the checker
//   xyzInput    : point address {x,y,z}, x in the MSBs
//   result_imp  : checker result for the point issued LAT cycles earlier
// master = sweep engine, slave = checker.
interface prm_xyz_sweep_if #(
    parameter int XW = 4,
    parameter int YW = 5,
    parameter int ZW = 5
);
    localparam int AW = XW + YW + ZW;

    logic [2:0]    sel1;
    logic [7:0]    sel2;
    logic [AW-1:0] xyzInput;
    logic [31:0]   result_imp;

    modport master (output sel1, output sel2, output xyzInput, input result_imp);
    modport slave  (input sel1, input sel2, input xyzInput, output result_imp);
endinterface

// File: rtl/prm_xyz_sweep.sv
// Exhaustive XYZ point sweep: issues every address 0..N-1 (N = 2^(XW+YW+ZW))
// to an external checker, one per cycle, and collects statistics over the
// results that return LAT cycles later.
// Ports:
//   CLK, RST_n            clock, asynchronous active-low reset
//   start, abort          sweep request (IDLE only) / cancel (busy only)
//   sel1_cfg, sel2_cfg    selectors, latched on an accepted start
//   chk_bus (master)      sel1/sel2/xyzInput out, result_imp in
//   busy, done            high in ISSUE/DRAIN; one-cycle completion pulse
//   hit_cnt, first_hit,   number of nonzero results, lowest hitting address
//   first_hit_vld, acc_or and its valid flag, OR of all sampled results
module prm_xyz_sweep #(
    parameter int XW  = 4,
    parameter int YW  = 5,
    parameter int ZW  = 5,
    parameter int LAT = 2
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2:0]            sel1_cfg,
    input  logic [7:0]            sel2_cfg,
    prm_xyz_sweep_if.master       chk_bus,
    output logic                  busy,
    output logic                  done,
    output logic [XW+YW+ZW:0]     hit_cnt,
    output logic [XW+YW+ZW-1:0]   first_hit,
    output logic                  first_hit_vld,
    output logic [31:0]           acc_or
);
    localparam int AW = XW + YW + ZW;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [3:0]    drain_q, drain_d;
    logic [LAT-1:0] vld_q;
    logic [AW-1:0] adr_q [LAT];
    logic [2:0]    sel1_q;
    logic [7:0]    sel2_q;
    logic [AW:0]   hit_q;
    logic [AW-1:0] fh_q;
    logic          fhv_q;
    logic [31:0]   acc_q;
    logic          start_acc;
    logic          abort_acc;
    logic          issue;
    logic          smp_vld;

    assign issue   = (state_q == ISSUE);
    assign smp_vld = vld_q[LAT-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        start_acc = 1'b0;
        abort_acc = abort && (state_q == ISSUE || state_q == DRAIN);
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = ISSUE;
                    cnt_d     = '0;
                end
            end
            ISSUE: begin
                // Leave on the last address instead of wrapping the counter.
                if (cnt_q == '1) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                    drain_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == 4'(LAT - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides any ISSUE->DRAIN or DRAIN->DONE move in this cycle.
        if (abort_acc) begin
            state_d = IDLE;
            cnt_d   = '0;
            drain_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    // Address/valid delay line aligning each issued point with its result.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) adr_q[i] <= '0;
        end else begin
            if (abort_acc) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= issue;
                for (int unsigned i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
            end
            adr_q[0] <= cnt_q;
            for (int unsigned i = 1; i < LAT; i++) adr_q[i] <= adr_q[i-1];
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sel1_q <= '0;
            sel2_q <= '0;
            hit_q  <= '0;
            fh_q   <= '0;
            fhv_q  <= 1'b0;
            acc_q  <= '0;
        end else if (start_acc) begin
            sel1_q <= sel1_cfg;
            sel2_q <= sel2_cfg;
            hit_q  <= '0;
            fh_q   <= '0;
            fhv_q  <= 1'b0;
            acc_q  <= '0;
        end else if (smp_vld) begin
            acc_q <= acc_q | chk_bus.result_imp;
            if (chk_bus.result_imp != '0) begin
                hit_q <= hit_q + 1'b1;
                if (!fhv_q) begin
                    fh_q  <= adr_q[LAT-1];
                    fhv_q <= 1'b1;
                end
            end
        end
    end

    assign chk_bus.sel1     = sel1_q;
    assign chk_bus.sel2     = sel2_q;
    assign chk_bus.xyzInput = issue ? cnt_q : '0;
    assign busy             = (state_q == ISSUE) || (state_q == DRAIN);
    assign done             = (state_q == DONE);
    assign hit_cnt          = hit_q;
    assign first_hit        = fh_q;
    assign first_hit_vld    = fhv_q;
    assign acc_or           = acc_q;
endmodule

// File: tb/tb_prm_xyz_sweep.sv
// Bench for prm_xyz_sweep: a small 1/1/1-bit instance with a scoreboard
// and a default-width instance for the full-size sweep.
module tb_prm_xyz_sweep;
    localparam int LAT = 2;
    localparam int N   = 8;
    localparam int NL  = 16384;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // small instance
    logic        start_s = 1'b0, abort_s = 1'b0;
    logic [2:0]  sel1_cfg_s = '0;
    logic [7:0]  sel2_cfg_s = '0;
    logic        busy_s, done_s, fhv_s;
    logic [3:0]  hit_s;
    logic [2:0]  fh_s;
    logic [31:0] acc_s;
    prm_xyz_sweep_if #(.XW(1), .YW(1), .ZW(1)) if_s ();

    prm_xyz_sweep #(.XW(1), .YW(1), .ZW(1), .LAT(LAT)) dut_s (
        .CLK(clk), .RST_n(rst_n), .start(start_s), .abort(abort_s),
        .sel1_cfg(sel1_cfg_s), .sel2_cfg(sel2_cfg_s), .chk_bus(if_s),
        .busy(busy_s), .done(done_s), .hit_cnt(hit_s), .first_hit(fh_s),
        .first_hit_vld(fhv_s), .acc_or(acc_s));

    // large instance, default widths
    logic        start_l = 1'b0, abort_l = 1'b0;
    logic [2:0]  sel1_cfg_l = '0;
    logic [7:0]  sel2_cfg_l = '0;
    logic        busy_l, done_l, fhv_l;
    logic [14:0] hit_l;
    logic [13:0] fh_l;
    logic [31:0] acc_l;
    prm_xyz_sweep_if if_l ();

    prm_xyz_sweep #(.LAT(LAT)) dut_l (
        .CLK(clk), .RST_n(rst_n), .start(start_l), .abort(abort_l),
        .sel1_cfg(sel1_cfg_l), .sel2_cfg(sel2_cfg_l), .chk_bus(if_l),
        .busy(busy_l), .done(done_l), .hit_cnt(hit_l), .first_hit(fh_l),
        .first_hit_vld(fhv_l), .acc_or(acc_l));

    // checker models: answer with the address seen LAT cycles ago
    logic [31:0] res_tab [N];
    logic [2:0]  hist_s [LAT];
    logic [13:0] hist_l [LAT];
    always @(posedge clk) begin
        hist_s[0] <= if_s.xyzInput;
        hist_l[0] <= if_l.xyzInput;
        for (int i = 1; i < LAT; i++) begin
            hist_s[i] <= hist_s[i-1];
            hist_l[i] <= hist_l[i-1];
        end
    end
    assign if_s.result_imp = res_tab[hist_s[LAT-1]];
    assign if_l.result_imp = 32'(hist_l[LAT-1]) + 32'd1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]  hit;
        logic [2:0]  fh;
        logic        fhv;
        logic [31:0] acc;
        logic        dn;
        int unsigned blen;
        logic [2:0]  s1;
        logic [7:0]  s2;
    } exp_t;

    exp_t q_s[$];

    // Expected statistics over the first k points of the sweep.
    function automatic exp_t model(input int k, input int blen, input bit dn,
                                   input logic [2:0] s1, input logic [7:0] s2);
        exp_t e;
        e.hit = '0; e.fh = '0; e.fhv = 1'b0; e.acc = '0;
        e.dn = dn; e.blen = blen; e.s1 = s1; e.s2 = s2;
        for (int i = 0; i < k; i++) begin
            e.acc |= res_tab[i];
            if (res_tab[i] != 0) begin
                e.hit = e.hit + 4'd1;
                if (!e.fhv) begin
                    e.fh  = 3'(i);
                    e.fhv = 1'b1;
                end
            end
        end
        return e;
    endfunction

    // monitor: evaluates each sweep when busy drops
    initial begin
        logic        prev_busy;
        int unsigned blen;
        logic [2:0]  obs[$];
        exp_t        e;
        int          bad;
        prev_busy = 1'b0;
        blen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
                blen = 0;
                obs.delete();
            end else begin
                if (busy_s) begin
                    obs.push_back(if_s.xyzInput);
                    blen++;
                end else if (prev_busy) begin
                    if (q_s.size() == 0) begin
                        check("unexpected_sweep_end", 32'(blen), 32'd0);
                    end else begin
                        e = q_s.pop_front();
                        check("done_flag", 32'(done_s), 32'(e.dn));
                        check("busy_len", 32'(blen), 32'(e.blen));
                        check("hit_cnt", 32'(hit_s), 32'(e.hit));
                        check("first_hit_vld", 32'(fhv_s), 32'(e.fhv));
                        check("first_hit", 32'(fh_s), 32'(e.fh));
                        check("acc_or", acc_s, e.acc);
                        check("sel1", 32'(if_s.sel1), 32'(e.s1));
                        check("sel2", 32'(if_s.sel2), 32'(e.s2));
                        bad = -1;
                        for (int i = 0; i < obs.size(); i++)
                            if (bad < 0 && obs[i] !== 3'((i < N) ? i : 0)) bad = i;
                        if (bad >= 0)
                            check("addr_seq", 32'(obs[bad]), 32'((bad < N) ? bad : 0));
                        else if (obs.size() > 0)
                            check("addr_seq", 32'(obs[obs.size()-1]),
                                  32'((obs.size()-1 < N) ? obs.size()-1 : 0));
                    end
                    blen = 0;
                    obs.delete();
                end else begin
                    check("no_spurious_done", 32'(done_s), 32'd0);
                end
                prev_busy = busy_s;
            end
        end
    end

    task automatic check_zero_s(input string nm);
        check({nm, "_busy"}, 32'(busy_s), 32'd0);
        check({nm, "_done"}, 32'(done_s), 32'd0);
        check({nm, "_xyz"}, 32'(if_s.xyzInput), 32'd0);
        check({nm, "_sel"}, {21'd0, if_s.sel1, if_s.sel2}, 32'd0);
        check({nm, "_hit"}, 32'(hit_s), 32'd0);
        check({nm, "_fh"}, {28'd0, fhv_s, fh_s}, 32'd0);
        check({nm, "_acc"}, acc_s, 32'd0);
    endtask

    // One sweep on the small instance. ab/mid/rst_at are cycle offsets from
    // the start cycle T (0 = not used).
    task automatic sweep(input int ab, input int mid, input int rst_at);
        logic [2:0] s1;
        logic [7:0] s2;
        exp_t e;
        int k;
        int unsigned w;
        s1 = 3'($urandom);
        s2 = 8'($urandom);
        @(negedge clk);
        sel1_cfg_s = s1;
        sel2_cfg_s = s2;
        start_s = 1'b1;
        if (rst_at != 0) begin
            e = model(0, 0, 1'b0, s1, s2);
        end else if (ab != 0) begin
            k = ab - LAT;
            if (k < 0) k = 0;
            if (k > N) k = N;
            e = model(k, ab, 1'b0, s1, s2);
            q_s.push_back(e);
        end else begin
            e = model(N, N + LAT, 1'b1, s1, s2);
            q_s.push_back(e);
        end
        @(negedge clk);
        start_s = 1'b0;
        sel1_cfg_s = 3'($urandom);
        sel2_cfg_s = 8'($urandom);
        for (int c = 1; c <= N + LAT + 1; c++) begin
            if (c == ab) abort_s = 1'b1;
            if (c == mid) begin
                start_s = 1'b1;
                sel1_cfg_s = ~s1;
            end
            if (c == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_zero_s("rst_mid");
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            abort_s = 1'b0;
            start_s = 1'b0;
        end
        w = 0;
        while (q_s.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check("sweep_timeout", 32'(q_s.size()), 32'd0);
        repeat (3) @(negedge clk);
        check("hold_hit", 32'(hit_s), 32'(e.hit));
        check("hold_acc", acc_s, e.acc);
        check("hold_fh", {28'd0, fhv_s, fh_s}, {28'd0, e.fhv, e.fh});
        check("hold_sel1", 32'(if_s.sel1), 32'(e.s1));
        check("idle_xyz", 32'(if_s.xyzInput), 32'd0);
    endtask

    initial begin
        int unsigned cyc, idx, done_at;
        logic [31:0] acc_exp;
        logic        seq_ok;
        for (int i = 0; i < N; i++) res_tab[i] = '0;
        #1 check_zero_s("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // full-size sweep, every result nonzero
        start_l = 1'b1;
        @(negedge clk);
        start_l = 1'b0;
        cyc = 1; idx = 0; done_at = 0; seq_ok = 1'b1;
        while (cyc < 20000 && done_at == 0) begin
            if (busy_l) begin
                if (if_l.xyzInput !== 14'((idx < NL) ? idx : 0)) seq_ok = 1'b0;
                idx++;
            end
            if (done_l) done_at = cyc;
            @(negedge clk);
            cyc++;
        end
        acc_exp = '0;
        for (int i = 0; i < NL; i++) acc_exp |= 32'(i + 1);
        check("big_done_cycle", done_at, 32'(NL + LAT + 1));
        check("big_busy_len", idx, 32'(NL + LAT));
        check("big_addr_seq", 32'(seq_ok), 32'(idx == NL + LAT));
        check("big_hit_cnt", 32'(hit_l), 32'(NL));
        check("big_first_hit", {17'd0, fhv_l, fh_l}, 32'h4000);
        check("big_acc_or", acc_l, acc_exp);

        // all results zero
        sweep(0, 0, 0);
        // odd addresses hit with 1<<addr
        for (int i = 0; i < N; i++) res_tab[i] = (i % 2 == 1) ? (32'h1 << i) : 32'h0;
        sweep(0, 0, 0);
        // abort at T+4, then an immediate new sweep
        sweep(4, 0, 0);
        sweep(0, 0, 0);
        // start pulse and sel change mid-sweep; start during DONE
        sweep(0, 3, 0);
        sweep(0, N + LAT + 1, 0);
        // abort on the last issue cycle and on the last drain cycle
        sweep(N, 0, 0);
        sweep(N + LAT, 0, 0);
        // reset mid-sweep, then restart
        sweep(0, 0, 6);
        check_zero_s("after_rst");
        for (int i = 0; i < N; i++) res_tab[i] = $urandom_range(0, 1) ? $urandom : 32'h0;
        sweep(0, 0, 0);
        // randomized sweeps
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++) res_tab[i] = $urandom_range(0, 2) != 0 ? $urandom : 32'h0;
            if ($urandom_range(0, 2) == 0) sweep($urandom_range(1, N + LAT), 0, 0);
            else sweep(0, ($urandom_range(0, 1) != 0) ? $urandom_range(1, N + LAT + 1) : 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
